// File: rtl/clic_lite_arbiter.sv
// Edge-latching interrupt arbiter that offers the highest-level eligible source to the core's CLIC port.
// Optional preemption through the kill handshake is enabled by defining CLIC_LITE_PREEMPT_KILL_EN.
module clic_lite_arbiter #(
    parameter int unsigned NumIrq     = 16,
    parameter int unsigned LevelWidth = 8,
    localparam int unsigned IdWidth   = $clog2(NumIrq)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumIrq-1:0]     irq_i,
    input  logic                  cfg_we_i,
    input  logic [IdWidth-1:0]    cfg_idx_i,
    input  logic                  cfg_ie_i,
    input  logic [LevelWidth-1:0] cfg_level_i,
    input  logic [1:0]            cfg_priv_i,
    input  logic                  cfg_shv_i,
    input  logic [LevelWidth-1:0] mintthresh_i,
    output logic                  clic_irq_valid_o,
    input  logic                  clic_irq_ready_i,
    output logic [IdWidth-1:0]    clic_irq_id_o,
    output logic [LevelWidth-1:0] clic_irq_level_o,
    output logic [1:0]            clic_irq_priv_o,
    output logic                  clic_irq_shv_o,
    output logic                  clic_kill_req_o,
    input  logic                  clic_kill_ack_i,
    output logic [NumIrq-1:0]     pending_o
);

    // state    | meaning
    // ST_IDLE  | no offer outstanding; registers the arbitration winner when one exists
    // ST_OFFER | offer presented with valid high, waiting for ready
    // ST_KILL  | stale offer withdrawn, kill_req high until the core acknowledges
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NumIrq-1:0]     irq_q, irq_d;
    logic [NumIrq-1:0]     pending_q, pending_d;
    logic [NumIrq-1:0]     cfg_ie_q, cfg_ie_d;
    logic [NumIrq-1:0]     cfg_shv_q, cfg_shv_d;
    logic [LevelWidth-1:0] cfg_level_q [NumIrq];
    logic [LevelWidth-1:0] cfg_level_d [NumIrq];
    logic [1:0]            cfg_priv_q  [NumIrq];
    logic [1:0]            cfg_priv_d  [NumIrq];

    logic                  valid_q, valid_d;
    logic                  kill_req_q, kill_req_d;
    logic [IdWidth-1:0]    offer_id_q, offer_id_d;
    logic [LevelWidth-1:0] offer_level_q, offer_level_d;
    logic [1:0]            offer_priv_q, offer_priv_d;
    logic                  offer_shv_q, offer_shv_d;

    logic [NumIrq-1:0]     eligible;
    logic [NumIrq-1:0]     clr;
    logic                  accept;
    logic                  win_found;
    logic [IdWidth-1:0]    win_id;
    logic [LevelWidth-1:0] win_level;

`ifndef CLIC_LITE_PREEMPT_KILL_EN
    logic                  unused_kill_ack;
    assign unused_kill_ack = clic_kill_ack_i;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumIrq; i++) begin
            eligible[i] = pending_q[i] & cfg_ie_q[i] & (cfg_level_q[i] > mintthresh_i);
        end
    end

    // >= lets a later (higher) index win ties on level.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_level = '0;
        for (int i = 0; i < NumIrq; i++) begin
            if (eligible[i] && (!win_found || cfg_level_q[i] >= win_level)) begin
                win_found = 1'b1;
                win_id    = IdWidth'(i);
                win_level = cfg_level_q[i];
            end
        end
    end

    always_comb begin
        cfg_ie_d    = cfg_ie_q;
        cfg_shv_d   = cfg_shv_q;
        cfg_level_d = cfg_level_q;
        cfg_priv_d  = cfg_priv_q;
        if (cfg_we_i) begin
            cfg_ie_d[cfg_idx_i]    = cfg_ie_i;
            cfg_shv_d[cfg_idx_i]   = cfg_shv_i;
            cfg_level_d[cfg_idx_i] = cfg_level_i;
            cfg_priv_d[cfg_idx_i]  = cfg_priv_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        kill_req_d    = kill_req_q;
        offer_id_d    = offer_id_q;
        offer_level_d = offer_level_q;
        offer_priv_d  = offer_priv_q;
        offer_shv_d   = offer_shv_q;
        accept        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d       = ST_OFFER;
                    valid_d       = 1'b1;
                    offer_id_d    = win_id;
                    offer_level_d = win_level;
                    offer_priv_d  = cfg_priv_q[win_id];
                    offer_shv_d   = cfg_shv_q[win_id];
                end
            end
            ST_OFFER: begin
                if (clic_irq_ready_i) begin
                    accept  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef CLIC_LITE_PREEMPT_KILL_EN
                else if ((win_found && (win_level > offer_level_q)) || !eligible[offer_id_q]) begin
                    valid_d    = 1'b0;
                    kill_req_d = 1'b1;
                    state_d    = ST_KILL;
                end
`endif
            end
            ST_KILL: begin
`ifdef CLIC_LITE_PREEMPT_KILL_EN
                if (clic_kill_ack_i) begin
                    kill_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new edge on the same cycle as the accept keeps the source pending.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[offer_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | (irq_i & ~irq_q);
        irq_d     = irq_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            irq_q         <= '0;
            pending_q     <= '0;
            cfg_ie_q      <= '0;
            cfg_shv_q     <= '0;
            for (int i = 0; i < NumIrq; i++) begin
                cfg_level_q[i] <= '0;
                cfg_priv_q[i]  <= 2'b11;
            end
            valid_q       <= 1'b0;
            kill_req_q    <= 1'b0;
            offer_id_q    <= '0;
            offer_level_q <= '0;
            offer_priv_q  <= 2'b11;
            offer_shv_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_q         <= irq_d;
            pending_q     <= pending_d;
            cfg_ie_q      <= cfg_ie_d;
            cfg_shv_q     <= cfg_shv_d;
            cfg_level_q   <= cfg_level_d;
            cfg_priv_q    <= cfg_priv_d;
            valid_q       <= valid_d;
            kill_req_q    <= kill_req_d;
            offer_id_q    <= offer_id_d;
            offer_level_q <= offer_level_d;
            offer_priv_q  <= offer_priv_d;
            offer_shv_q   <= offer_shv_d;
        end
    end

    assign clic_irq_valid_o = valid_q;
    assign clic_irq_id_o    = offer_id_q;
    assign clic_irq_level_o = offer_level_q;
    assign clic_irq_priv_o  = offer_priv_q;
    assign clic_irq_shv_o   = offer_shv_q;
    assign clic_kill_req_o  = kill_req_q;
    assign pending_o        = pending_q;

endmodule

// File: tb/tb_clic_lite_arbiter.sv
// Scoreboard bench for clic_lite_arbiter: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares them; directed scenarios plus a randomized run.
module tb_clic_lite_arbiter;
    localparam int N  = 16;
    localparam int LW = 8;
    localparam int IW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic [N-1:0]  irq_i = '0;
    logic          cfg_we_i = 1'b0;
    logic [IW-1:0] cfg_idx_i = '0;
    logic          cfg_ie_i = 1'b0;
    logic [LW-1:0] cfg_level_i = '0;
    logic [1:0]    cfg_priv_i = '0;
    logic          cfg_shv_i = 1'b0;
    logic [LW-1:0] mintthresh_i = '0;
    logic          clic_irq_ready_i = 1'b0;
    logic          clic_kill_ack_i = 1'b0;
    logic          clic_irq_valid_o;
    logic [IW-1:0] clic_irq_id_o;
    logic [LW-1:0] clic_irq_level_o;
    logic [1:0]    clic_irq_priv_o;
    logic          clic_irq_shv_o;
    logic          clic_kill_req_o;
    logic [N-1:0]  pending_o;

    always #5 clk_i = ~clk_i;

    clic_lite_arbiter #(.NumIrq(N), .LevelWidth(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_ie_i(cfg_ie_i),
        .cfg_level_i(cfg_level_i), .cfg_priv_i(cfg_priv_i), .cfg_shv_i(cfg_shv_i),
        .mintthresh_i(mintthresh_i),
        .clic_irq_valid_o(clic_irq_valid_o), .clic_irq_ready_i(clic_irq_ready_i),
        .clic_irq_id_o(clic_irq_id_o), .clic_irq_level_o(clic_irq_level_o),
        .clic_irq_priv_o(clic_irq_priv_o), .clic_irq_shv_o(clic_irq_shv_o),
        .clic_kill_req_o(clic_kill_req_o), .clic_kill_ack_i(clic_kill_ack_i),
        .pending_o(pending_o)
    );

    typedef struct {
        bit valid; bit kill; int id; int lvl; int priv; bit shv; int pend;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 = no offer, 1 = offering, 2 = withdrawing
    bit m_pend[N], m_prev[N], m_ie[N], m_shv[N];
    int m_lvl[N], m_priv[N];
    int m_mode;
    bit m_valid, m_kill, m_oshv;
    int m_id, m_olvl, m_opriv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_prev[i] = 0; m_ie[i] = 0; m_shv[i] = 0;
            m_lvl[i] = 0; m_priv[i] = 3;
        end
        m_mode = 0; m_valid = 0; m_kill = 0; m_oshv = 0;
        m_id = 0; m_olvl = 0; m_opriv = 3;
    endfunction

    function automatic void model_step();
        bit elig[N];
        int maxl = -1;
        int best = -1;
        bit accept;
        for (int i = 0; i < N; i++) begin
            elig[i] = m_pend[i] && m_ie[i] && (m_lvl[i] > int'(mintthresh_i));
            if (elig[i] && m_lvl[i] > maxl) maxl = m_lvl[i];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (best < 0 && elig[i] && m_lvl[i] == maxl) best = i;
        end
        accept = (m_mode == 1) && clic_irq_ready_i;
        if (m_mode == 0) begin
            if (best >= 0) begin
                m_mode = 1; m_valid = 1; m_id = best;
                m_olvl = m_lvl[best]; m_opriv = m_priv[best]; m_oshv = m_shv[best];
            end
        end else if (m_mode == 1) begin
            if (accept) begin
                m_mode = 0; m_valid = 0;
            end
`ifdef CLIC_LITE_PREEMPT_KILL_EN
            else if ((best >= 0 && maxl > m_olvl) || !elig[m_id]) begin
                m_mode = 2; m_valid = 0; m_kill = 1;
            end
`endif
        end else begin
            if (clic_kill_ack_i) begin
                m_mode = 0; m_kill = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (accept && m_id == i) m_pend[i] = 0;
            if (irq_i[i] && !m_prev[i]) m_pend[i] = 1;
            m_prev[i] = irq_i[i];
        end
        if (cfg_we_i) begin
            m_ie[cfg_idx_i] = cfg_ie_i; m_lvl[cfg_idx_i] = int'(cfg_level_i);
            m_priv[cfg_idx_i] = int'(cfg_priv_i); m_shv[cfg_idx_i] = cfg_shv_i;
        end
    endfunction

    function automatic int model_pend_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic cycle();
        exp_t e;
        @(posedge clk_i);
        if (rst_ni) begin
            model_step();
            e.valid = m_valid; e.kill = m_kill; e.id = m_id; e.lvl = m_olvl;
            e.priv = m_opriv; e.shv = m_oshv; e.pend = model_pend_vec();
            exp_q.push_back(e);
        end
        #1;
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_valid", int'(clic_irq_valid_o), int'(e.valid));
            chk("sb_kill_req", int'(clic_kill_req_o), int'(e.kill));
            chk("sb_id", int'(clic_irq_id_o), e.id);
            chk("sb_level", int'(clic_irq_level_o), e.lvl);
            chk("sb_priv", int'(clic_irq_priv_o), e.priv);
            chk("sb_shv", int'(clic_irq_shv_o), int'(e.shv));
            chk("sb_pending", int'(pending_o), e.pend);
        end
    end

    task automatic apply_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        irq_i = '0; cfg_we_i = 0; clic_irq_ready_i = 0; clic_kill_ack_i = 0; mintthresh_i = '0;
        #1;
        chk("rst_valid", int'(clic_irq_valid_o), 0);
        chk("rst_kill_req", int'(clic_kill_req_o), 0);
        chk("rst_id", int'(clic_irq_id_o), 0);
        chk("rst_level", int'(clic_irq_level_o), 0);
        chk("rst_priv", int'(clic_irq_priv_o), 3);
        chk("rst_shv", int'(clic_irq_shv_o), 0);
        chk("rst_pending", int'(pending_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        rst_ni = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input bit ie, input int lvl, input int priv, input bit shv);
        cfg_we_i = 1; cfg_idx_i = IW'(idx); cfg_ie_i = ie;
        cfg_level_i = LW'(lvl); cfg_priv_i = 2'(priv); cfg_shv_i = shv;
        cycle();
        cfg_we_i = 0;
    endtask

    task automatic wait_offer(input string name, input int exp_id, input int budget);
        int n = 0;
        while (!clic_irq_valid_o && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_valid"}, int'(clic_irq_valid_o), 1);
        chk({name, "_id"}, int'(clic_irq_id_o), exp_id);
    endtask

    initial begin
        #2;
        apply_reset();

        // Single source: offer two cycles after the edge, then accept
        cfg_write(3, 1, 5, 1, 1);
        irq_i[3] = 1;
        cycle();
        chk("s1_valid_early", int'(clic_irq_valid_o), 0);
        cycle();
        chk("s1_valid", int'(clic_irq_valid_o), 1);
        chk("s1_id", int'(clic_irq_id_o), 3);
        chk("s1_level", int'(clic_irq_level_o), 5);
        clic_irq_ready_i = 1;
        cycle();
        clic_irq_ready_i = 0;
        chk("s1_pending3", int'(pending_o[3]), 0);
        chk("s1_valid_after", int'(clic_irq_valid_o), 0);
        repeat (3) cycle();
        apply_reset();

        // Equal levels: higher index first
        cfg_write(2, 1, 9, 0, 0);
        cfg_write(7, 1, 9, 2, 1);
        irq_i[2] = 1; irq_i[7] = 1;
        cycle();
        wait_offer("s2_first", 7, 4);
        clic_irq_ready_i = 1;
        cycle();
        clic_irq_ready_i = 0;
        wait_offer("s2_second", 2, 4);
        clic_irq_ready_i = 1;
        cycle();
        clic_irq_ready_i = 0;
        repeat (3) cycle();
        apply_reset();

        // Threshold boundary: level == threshold is not eligible
        cfg_write(4, 1, 3, 1, 0);
        mintthresh_i = 3;
        irq_i[4] = 1;
        repeat (5) cycle();
        chk("s3_no_valid", int'(clic_irq_valid_o), 0);
        mintthresh_i = 2;
        wait_offer("s3_offer", 4, 4);
        clic_irq_ready_i = 1;
        cycle();
        clic_irq_ready_i = 0;
        repeat (2) cycle();
        apply_reset();

        // Higher level arriving during an unaccepted offer
        cfg_write(1, 1, 4, 0, 0);
        cfg_write(5, 1, 10, 3, 1);
        irq_i[1] = 1;
        cycle();
        wait_offer("s4_first", 1, 4);
        irq_i[5] = 1;
        repeat (3) cycle();
`ifdef CLIC_LITE_PREEMPT_KILL_EN
        chk("s4_kill_req", int'(clic_kill_req_o), 1);
        chk("s4_valid_killed", int'(clic_irq_valid_o), 0);
        clic_kill_ack_i = 1;
        cycle();
        clic_kill_ack_i = 0;
        chk("s4_kill_done", int'(clic_kill_req_o), 0);
        wait_offer("s4_next", 5, 4);
        chk("s4_pending1", int'(pending_o[1]), 1);
`else
        chk("s4_held_valid", int'(clic_irq_valid_o), 1);
        chk("s4_held_id", int'(clic_irq_id_o), 1);
        chk("s4_no_kill", int'(clic_kill_req_o), 0);
`endif
        clic_irq_ready_i = 1;
        cycle();
        clic_irq_ready_i = 0;
        repeat (4) cycle();
        apply_reset();

        // Re-raise on the accept cycle keeps the source pending
        cfg_write(6, 1, 7, 2, 0);
        irq_i[6] = 1;
        cycle();
        irq_i[6] = 0;
        wait_offer("s5_first", 6, 4);
        clic_irq_ready_i = 1; irq_i[6] = 1;
        cycle();
        clic_irq_ready_i = 0; irq_i[6] = 0;
        chk("s5_pending6", int'(pending_o[6]), 1);
        wait_offer("s5_again", 6, 4);
        repeat (2) cycle();
        apply_reset();

        // Reset while a kill (or held offer) is outstanding
        cfg_write(1, 1, 4, 0, 0);
        cfg_write(5, 1, 10, 3, 1);
        irq_i[1] = 1;
        repeat (3) cycle();
        irq_i[5] = 1;
        repeat (3) cycle();
        apply_reset();

        // Randomized run
        for (int c = 0; c < 4000; c++) begin
            irq_i = irq_i ^ N'($urandom & $urandom & $urandom);
            cfg_we_i = ($urandom_range(0, 5) == 0);
            cfg_idx_i = IW'($urandom_range(0, N - 1));
            cfg_ie_i = ($urandom_range(0, 3) != 0);
            cfg_level_i = LW'($urandom_range(0, 15));
            cfg_priv_i = 2'($urandom_range(0, 3));
            cfg_shv_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) mintthresh_i = LW'($urandom_range(0, 8));
            clic_irq_ready_i = ($urandom_range(0, 3) == 0);
            clic_kill_ack_i = ($urandom_range(0, 2) == 0);
            cycle();
        end
        cfg_we_i = 0; clic_irq_ready_i = 0; clic_kill_ack_i = 0;
        repeat (2) cycle();
        @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
